// File: rtl/func_acc_pkg.sv
// Command codes, FSM state encodings and float constants shared by the func_accumulator slice.
package func_acc_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR       = 2'd0,
        CMD_GO          = 2'd1,
        CMD_READ        = 2'd2,
        CMD_READ_STATUS = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EVAL     = 3'd1,
        ST_ADD_PAIR = 3'd2,
        ST_ADD_ACC  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/func_accumulator_if.sv
// Command, evaluator and adder handshake bundle; slave is the accumulator's view, master the environment's.
interface func_accumulator_if #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2
);
    logic                      clk_en;
    logic                      start;
    logic [N_WIDTH-1:0]        n;
    logic [FLT_DATA_WIDTH-1:0] x_one;
    logic [FLT_DATA_WIDTH-1:0] x_two;
    logic [FLT_DATA_WIDTH-1:0] result;
    logic                      done;
    logic                      eval_start;
    logic [FLT_DATA_WIDTH-1:0] eval_x_one;
    logic [FLT_DATA_WIDTH-1:0] eval_x_two;
    logic                      eval_done;
    logic [FLT_DATA_WIDTH-1:0] eval_y_one;
    logic [FLT_DATA_WIDTH-1:0] eval_y_two;
    logic                      add_valid;
    logic [FLT_DATA_WIDTH-1:0] add_a;
    logic [FLT_DATA_WIDTH-1:0] add_b;
    logic                      add_done;
    logic [FLT_DATA_WIDTH-1:0] add_sum;

    modport slave (
        input  clk_en, start, n, x_one, x_two,
        input  eval_done, eval_y_one, eval_y_two, add_done, add_sum,
        output result, done, eval_start, eval_x_one, eval_x_two,
        output add_valid, add_a, add_b
    );

    modport master (
        output clk_en, start, n, x_one, x_two,
        output eval_done, eval_y_one, eval_y_two, add_done, add_sum,
        input  result, done, eval_start, eval_x_one, eval_x_two,
        input  add_valid, add_a, add_b
    );

endinterface

// File: rtl/func_acc_watchdog.sv
// Handshake watchdog: down-counter reloaded on every wait-state entry, expired at terminal count.
// Only compiled when FUNC_ACC_TIMEOUT_EN is defined.
`ifdef FUNC_ACC_TIMEOUT_EN
module func_acc_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en_i,
    input  logic restart_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Loaded on the entry edge, so reaching zero marks TIMEOUT_CYCLES cycles spent in the state.
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= LOAD;
        end else if (clk_en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/func_accumulator.sv
// Evaluates f(x_one)+f(x_two) through external evaluator/adder handshakes and accumulates into sum.
// Optional handshake watchdog with sticky error flag: define FUNC_ACC_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | wait for start; CLEAR/READ/READ_STATUS resolve here
//   EVAL     | evaluator launched, wait for eval_done
//   ADD_PAIR | adder computing f(x_one)+f(x_two)
//   ADD_ACC  | adder folding the pair sum into the accumulator
//   DONE     | one-cycle done pulse, back to IDLE
module func_accumulator
    import func_acc_pkg::*;
#(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    func_accumulator_if.slave bus
);
    localparam int W = FLT_DATA_WIDTH;

    if (COUNT_WIDTH > FLT_DATA_WIDTH - 1 || N_WIDTH != 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("func_accumulator: COUNT_WIDTH must sit below the error bit, N_WIDTH must be 2, TIMEOUT_CYCLES >= 2");
    end

    state_e                 state_q, state_d;
    logic [W-1:0]           result_q, result_d;
    logic                   done_q, done_d;
    logic                   eval_start_q, eval_start_d;
    logic                   add_valid_q, add_valid_d;
    logic [W-1:0]           eval_x_one_q, eval_x_one_d;
    logic [W-1:0]           eval_x_two_q, eval_x_two_d;
    logic [W-1:0]           add_a_q, add_a_d;
    logic [W-1:0]           add_b_q, add_b_d;
    logic [W-1:0]           sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   error_q, error_d;
    logic [W-1:0]           status;

    always_comb begin
        status                  = '0;
        status[W-1]             = error_q;
        status[COUNT_WIDTH-1:0] = count_q;
    end

`ifdef FUNC_ACC_TIMEOUT_EN
    logic wd_restart;
    logic wd_expired;

    assign wd_restart = (state_d != state_q);

    func_acc_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clk_en_i  (bus.clk_en),
        .restart_i (wd_restart),
        .expired_o (wd_expired)
    );
`endif

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        done_d       = 1'b0;
        eval_start_d = 1'b0;
        add_valid_d  = 1'b0;
        eval_x_one_d = eval_x_one_q;
        eval_x_two_d = eval_x_two_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        sum_d        = sum_q;
        count_d      = count_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (cmd_e'(bus.n))
                        CMD_CLEAR: begin
                            sum_d    = '0;
                            count_d  = '0;
                            error_d  = 1'b0;
                            result_d = '0;
                            state_d  = ST_DONE;
                        end
                        CMD_GO: begin
                            eval_x_one_d = bus.x_one;
                            eval_x_two_d = bus.x_two;
                            eval_start_d = 1'b1;
                            state_d      = ST_EVAL;
                        end
                        CMD_READ: begin
                            result_d = sum_q;
                            state_d  = ST_DONE;
                        end
                        default: begin
                            result_d = status;
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_EVAL: begin
                // A done coincident with our own launch pulse belongs to an earlier request.
                if (bus.eval_done && !eval_start_q) begin
                    add_a_d     = bus.eval_y_one;
                    add_b_d     = bus.eval_y_two;
                    add_valid_d = 1'b1;
                    state_d     = ST_ADD_PAIR;
                end
            end
            ST_ADD_PAIR: begin
                if (bus.add_done) begin
                    add_a_d     = sum_q;
                    add_b_d     = bus.add_sum;
                    add_valid_d = 1'b1;
                    state_d     = ST_ADD_ACC;
                end
            end
            ST_ADD_ACC: begin
                if (bus.add_done) begin
                    sum_d    = bus.add_sum;
                    result_d = bus.add_sum;
                    count_d  = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef FUNC_ACC_TIMEOUT_EN
        // A handshake completing on the expiry cycle still wins over the abort.
        if (wd_expired && (state_d == state_q) &&
            (state_q inside {ST_EVAL, ST_ADD_PAIR, ST_ADD_ACC})) begin
            error_d     = 1'b1;
            result_d    = W'(QNAN);
            add_valid_d = 1'b0;
            state_d     = ST_DONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            result_q     <= '0;
            done_q       <= 1'b0;
            eval_start_q <= 1'b0;
            add_valid_q  <= 1'b0;
            eval_x_one_q <= '0;
            eval_x_two_q <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            sum_q        <= '0;
            count_q      <= '0;
            error_q      <= 1'b0;
        end else if (bus.clk_en) begin
            state_q      <= state_d;
            result_q     <= result_d;
            done_q       <= done_d;
            eval_start_q <= eval_start_d;
            add_valid_q  <= add_valid_d;
            eval_x_one_q <= eval_x_one_d;
            eval_x_two_q <= eval_x_two_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            sum_q        <= sum_d;
            count_q      <= count_d;
            error_q      <= error_d;
        end
    end

    assign bus.result     = result_q;
    assign bus.done       = done_q;
    assign bus.eval_start = eval_start_q;
    assign bus.eval_x_one = eval_x_one_q;
    assign bus.eval_x_two = eval_x_two_q;
    assign bus.add_valid  = add_valid_q;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;

endmodule

// File: tb/tb_func_accumulator.sv
// Scoreboard bench for func_accumulator: identity evaluator and float adder models, directed commands.
module tb_func_accumulator;
    import func_acc_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    int          eval_cnt = 0;
    int          add_cnt = 0;
    bit          eval_mute = 1'b0;
    bit          eval_glitch = 1'b0;
    int          stray_req = 0;
    int          stray_ack = 0;
    logic [31:0] add_a_lat = '0;
    logic [31:0] add_b_lat = '0;

    func_accumulator_if #(.FLT_DATA_WIDTH(W), .N_WIDTH(2)) bus ();

    func_accumulator #(
        .FLT_DATA_WIDTH (W),
        .N_WIDTH        (2),
        .COUNT_WIDTH    (16),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        for (int i = 0; i < e; i++) v = v * 2.0;
        for (int i = 0; i > e; i--) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Evaluator answers 3 cycles after launch, adder 2 cycles after launch; both pulse for one cycle.
    always @(negedge clk) begin
        bus.eval_done = 1'b0;
        bus.add_done  = 1'b0;
        if (eval_cnt > 0) begin
            eval_cnt = eval_cnt - 1;
            if (eval_cnt == 0) begin
                bus.eval_done  = 1'b1;
                bus.eval_y_one = bus.eval_x_one;
                bus.eval_y_two = bus.eval_x_two;
            end
        end
        if (add_cnt > 0) begin
            add_cnt = add_cnt - 1;
            if (add_cnt == 0) begin
                bus.add_done = 1'b1;
                bus.add_sum  = r2f(f2r(add_a_lat) + f2r(add_b_lat));
            end
        end
        if (bus.eval_start === 1'b1 && !eval_mute) begin
            eval_cnt = 3;
            if (eval_glitch) begin
                bus.eval_done  = 1'b1;
                bus.eval_y_one = 32'h4040_0000;
                bus.eval_y_two = 32'h4040_0000;
            end
        end
        if (bus.add_valid === 1'b1) begin
            add_cnt   = 2;
            add_a_lat = bus.add_a;
            add_b_lat = bus.add_b;
        end
        if (stray_req != stray_ack) begin
            stray_ack    = stray_req;
            bus.add_done = 1'b1;
            bus.add_sum  = 32'h1234_5678;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=%h, required no completion", bus.result);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_result"}, bus.result, e.res);
                if (e.cyc >= 0) chk({e.name, "_latency_cycle"}, cyc, e.cyc);
            end
        end
    endtask

    task automatic issue(input cmd_e cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int lat, input string name);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = cmd;
        bus.x_one = a;
        bus.x_two = b;
        e.res  = exp_res;
        e.cyc  = (lat >= 0) ? cyc + lat : -1;
        e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d completions pending after %0d cycles, required 0", sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: still running at time %0t, required completion", $time);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int k;
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.n      = '0;
        bus.x_one  = '0;
        bus.x_two  = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_done", {31'b0, bus.done}, 32'h0);
        chk("rst_eval_start", {31'b0, bus.eval_start}, 32'h0);
        chk("rst_add_valid", {31'b0, bus.add_valid}, 32'h0);
        chk("rst_eval_x_one", bus.eval_x_one, 32'h0);
        chk("rst_eval_x_two", bus.eval_x_two, 32'h0);
        chk("rst_add_a", bus.add_a, 32'h0);
        chk("rst_add_b", bus.add_b, 32'h0);
        rst = 1'b1;

        issue(CMD_READ, '0, '0, 32'h0000_0000, 2, "read_after_rst");
        drain(20);
        issue(CMD_GO, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, -1, "go_1_2");
        drain(100);
        issue(CMD_READ_STATUS, '0, '0, 32'h0000_0001, 2, "status_1");
        drain(20);
        issue(CMD_GO, 32'h3F80_0000, 32'h3F80_0000, 32'h40A0_0000, -1, "go_1_1");
        drain(100);
        issue(CMD_READ_STATUS, '0, '0, 32'h0000_0002, 2, "status_2");
        drain(20);
        issue(CMD_READ, '0, '0, 32'h40A0_0000, 2, "read_5");
        drain(20);
        issue(CMD_CLEAR, '0, '0, 32'h0000_0000, 2, "clear");
        drain(20);
        issue(CMD_READ, '0, '0, 32'h0000_0000, 2, "read_cleared");
        drain(20);
        issue(CMD_READ_STATUS, '0, '0, 32'h0000_0000, 2, "status_cleared");
        drain(20);

        // GO with a coincident eval_done on launch and a CLEAR strobe while in EVAL; both must be ignored.
        eval_glitch = 1'b1;
        issue(CMD_GO, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, -1, "go_ignored_start");
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = CMD_CLEAR;
        @(negedge clk);
        bus.start = 1'b0;
        drain(100);
        eval_glitch = 1'b0;
        issue(CMD_READ_STATUS, '0, '0, 32'h0000_0001, 2, "status_after_ignored");
        drain(20);

        stray_req++;
        repeat (3) @(negedge clk);
        issue(CMD_READ, '0, '0, 32'h4080_0000, 2, "read_after_stray_add");
        drain(20);

        @(negedge clk);
        bus.clk_en = 1'b0;
        bus.start  = 1'b1;
        bus.n      = CMD_CLEAR;
        repeat (4) @(negedge clk);
        chk("freeze_done", {31'b0, bus.done}, 32'h0);
        chk("freeze_result", bus.result, 32'h4080_0000);
        bus.start = 1'b0;
        @(negedge clk);
        bus.clk_en = 1'b1;
        issue(CMD_READ, '0, '0, 32'h4080_0000, 2, "read_after_freeze");
        drain(20);

`ifdef FUNC_ACC_TIMEOUT_EN
        eval_mute = 1'b1;
        issue(CMD_GO, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 257, "go_timeout");
        drain(400);
        eval_mute = 1'b0;
        issue(CMD_READ_STATUS, '0, '0, 32'h8000_0001, 2, "status_timeout");
        drain(20);
        issue(CMD_READ, '0, '0, 32'h4080_0000, 2, "read_after_timeout");
        drain(20);
`endif

        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = CMD_GO;
        bus.x_one = 32'h3F80_0000;
        bus.x_two = 32'h4000_0000;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.add_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reach_add_pair", {31'b0, bus.add_valid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst_result", bus.result, 32'h0);
        chk("midrst_add_valid", {31'b0, bus.add_valid}, 32'h0);
        chk("midrst_eval_x_one", bus.eval_x_one, 32'h0);
        chk("midrst_add_a", bus.add_a, 32'h0);
        chk("midrst_add_b", bus.add_b, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        stray_req++;
        repeat (4) @(negedge clk);
        issue(CMD_READ, '0, '0, 32'h0000_0000, 2, "read_after_midrst");
        drain(20);
        issue(CMD_READ_STATUS, '0, '0, 32'h0000_0000, 2, "status_after_midrst");
        drain(20);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
